// File: rtl/mux_arb_pkg.sv
// Shared definitions for the 8-requester round-robin mux arbiter.
// Contents: requester count, select width, hold-counter width,
// FSM state enum and the requester index type.
package mux_arb_pkg;

  localparam int unsigned NREQ  = 8;
  localparam int unsigned SEL_W = 3;
  localparam int unsigned CNT_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  typedef logic [SEL_W-1:0] idx_t;

endpackage

// File: rtl/mux_arbiter_rr_pick.sv
// Combinational rotating-priority pick.
// Ports:
//   req   [7:0] in  request vector
//   start [2:0] in  index searched first; search wraps modulo 8
//   mask  [7:0] in  1 = requester eligible
//   found       out at least one eligible request
//   idx   [2:0] out first eligible requester in search order
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] start,
  input  logic [NREQ-1:0]  mask,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [NREQ-1:0] w_elig;
  idx_t            w_cand;

  assign w_elig = req & mask;

  // Walk offsets 0..7 from start; the first hit wins.
  always_comb begin
    found  = 1'b0;
    idx    = '0;
    w_cand = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_cand = idx_t'(start + idx_t'(i));
      if (!found && w_elig[w_cand]) begin
        found = 1'b1;
        idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin arbiter owning the select of an 8:1 mux.
// Optional hold timeout compiled in with `define MUX_ARB_TIMEOUT_EN.
// Ports:
//   clk            in   system clock, rising edge
//   rst            in   synchronous active-high reset
//   req  [7:0]     in   level-sensitive requests
//   gnt  [7:0]     out  registered one-hot grant, zero when idle
//   sel  [2:0]     out  registered owner index, held while idle
//   busy           out  registered OR of gnt
//   owner_last     out  final cycle of a timed-out hold (0 without timeout)
module mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  gnt,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             owner_last
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("mux_arbiter: MAX_HOLD must be in 1..255");
  end

  arb_state_t      r_state, w_state_nxt;
  idx_t            r_sel, w_sel_nxt;
  idx_t            r_last, w_last_nxt;
  logic [NREQ-1:0] r_gnt, w_gnt_nxt;
  logic            r_busy;

  logic            w_found;
  idx_t            w_idx;
  idx_t            w_start;
  logic [NREQ-1:0] w_mask;
  logic            w_hold_done;
  logic            w_keep;

  // Search begins just after the most recent owner; the current owner
  // is excluded so a release or timeout always moves on if it can.
  assign w_start = idx_t'(r_last + idx_t'(1));
  assign w_mask  = (r_state == GRANT) ? ~(NREQ'(1) << r_sel) : '1;

  rr_pick u_pick (
    .req   (req),
    .start (w_start),
    .mask  (w_mask),
    .found (w_found),
    .idx   (w_idx)
  );

`ifdef MUX_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_owner_last, w_owner_last_nxt;

  assign w_hold_done = (r_cnt == CNT_W'(MAX_HOLD - 1));

  // Count cycles of the current hold; any fresh grant restarts at 0.
  always_comb begin
    w_cnt_nxt        = '0;
    w_owner_last_nxt = 1'b0;
    if (w_keep) begin
      w_cnt_nxt = CNT_W'(r_cnt + CNT_W'(1));
    end
    if (w_state_nxt == GRANT) begin
      w_owner_last_nxt = (w_cnt_nxt == CNT_W'(MAX_HOLD - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_owner_last <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_owner_last <= w_owner_last_nxt;
    end
  end

  assign owner_last = r_owner_last;
`else
  assign w_hold_done = 1'b0;
  assign owner_last  = 1'b0;
`endif

  assign w_keep = (r_state == GRANT) && req[r_sel] && !w_hold_done;

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_last_nxt  = r_last;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = GRANT;
          w_sel_nxt   = w_idx;
          w_last_nxt  = w_idx;
        end
      end
      GRANT: begin
        if (!w_keep) begin
          if (w_found) begin
            w_sel_nxt  = w_idx;
            w_last_nxt = w_idx;
          end else if (!req[r_sel]) begin
            w_state_nxt = IDLE;
          end
          // Otherwise a timed-out owner with no competitor is re-granted.
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    w_gnt_nxt = (w_state_nxt == GRANT) ? (NREQ'(1) << w_sel_nxt) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_last  <= idx_t'(NREQ - 1);
      r_gnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_last  <= w_last_nxt;
      r_gnt   <= w_gnt_nxt;
      r_busy  <= |w_gnt_nxt;
    end
  end

  assign gnt  = r_gnt;
  assign sel  = r_sel;
  assign busy = r_busy;

endmodule
